sync_ram_ctrl: RTL and testbench

//   Parametrised single-port synchronous RAM with request/ready handshake,

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_rd_pipe.sv | 42 ++++
 rtl/sync_ram_ctrl.sv | 78 +++++++
 tb/tb_sync_ram_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the synchronous RAM controller
package mem_pkg;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    function automatic bit read_lat_ok(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - valid/data read pipeline; last stage holds the most recent read result
module mem_rd_pipe #(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   dat_q [READ_LAT];

    // Data stages only advance with a valid token, so the final stage keeps
    // the last read value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[READ_LAT-1];
    assign out_data  = dat_q[READ_LAT-1];

endmodule

// File: rtl/sync_ram_ctrl.sv
// rtl/sync_ram_ctrl.sv - single-port synchronous RAM with init clear, ready handshake and read pipe
module sync_ram_ctrl
    import mem_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 4,
    parameter int                 READ_LAT = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enable,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address_bus,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic [DATA_W-1:0] data_bus_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              req_dropped
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic accept;
    logic rd_accept;
    logic wr_accept;
    logic last_init;

    // ready is high only in RUN, so it alone gates request acceptance.
    assign accept    = mem_enable & ready;
    assign rd_accept = accept & (read_write == OP_READ);
    assign wr_accept = accept & (read_write == OP_WRITE);
    assign last_init = (state == ST_INIT) && (init_cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            ready       <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            req_dropped <= mem_enable & ~ready;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (last_init) begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
            end
        end
    end

    // The array itself has no reset; the INIT sweep rewrites every word.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= INIT_VAL;
        end else if (wr_accept) begin
            mem[address_bus] <= data_bus_in;
        end
    end

    mem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_accept),
        .in_data   (mem[address_bus]),
        .out_valid (rd_valid),
        .out_data  (data_bus_out)
    );

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// tb/tb_sync_ram_ctrl.sv - self-checking bench: three latency variants, reference model, vector table
module tb_sync_ram_ctrl;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_enable;
    logic       read_write;
    logic [3:0] address_bus;
    logic [7:0] data_bus_in;

    logic [7:0] dout [3];
    logic       rv   [3];
    logic       rdy  [3];
    logic       drop [3];

    always #5 clk = ~clk;

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1), .INIT_VAL(8'h00)) u_lat1 (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .read_write(read_write),
        .address_bus(address_bus), .data_bus_in(data_bus_in),
        .data_bus_out(dout[0]), .rd_valid(rv[0]), .ready(rdy[0]), .req_dropped(drop[0]));

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2), .INIT_VAL(8'h00)) u_lat2 (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .read_write(read_write),
        .address_bus(address_bus), .data_bus_in(data_bus_in),
        .data_bus_out(dout[1]), .rd_valid(rv[1]), .ready(rdy[1]), .req_dropped(drop[1]));

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .READ_LAT(3), .INIT_VAL(8'h00)) u_lat3 (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .read_write(read_write),
        .address_bus(address_bus), .data_bus_in(data_bus_in),
        .data_bus_out(dout[2]), .rd_valid(rv[2]), .ready(rdy[2]), .req_dropped(drop[2]));

    always @(posedge clk) begin
        if (mem_enable === 1'b1) begin
            assert (!$isunknown(read_write)) else $error("read_write unknown during request");
        end
    end

    // Reference model: word array, cycles since reset, and per-latency queues
    // of read results tagged with the edge number at which they must appear.
    typedef struct {
        int         due;
        logic [7:0] d;
    } rd_t;

    logic [7:0] ref_mem [DEPTH];
    rd_t        rq [3][$];
    int         since;
    int         edge_n;
    logic       exp_v [3];
    logic [7:0] exp_d [3];
    logic       exp_drop;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset();
        since    = 0;
        exp_drop = 1'b0;
        for (int l = 0; l < 3; l++) begin
            rq[l].delete();
            exp_v[l] = 1'b0;
            exp_d[l] = 8'h00;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic model_edge();
        bit ok = (since >= DEPTH);
        rd_t r;
        exp_drop = mem_enable && !ok;
        if (mem_enable && ok) begin
            if (read_write) begin
                for (int l = 0; l < 3; l++) begin
                    r.due = edge_n + l;
                    r.d   = ref_mem[address_bus];
                    rq[l].push_back(r);
                end
            end else begin
                ref_mem[address_bus] = data_bus_in;
            end
        end
        if (since < DEPTH) since++;
        for (int l = 0; l < 3; l++) begin
            exp_v[l] = 1'b0;
            if (rq[l].size() > 0 && rq[l][0].due == edge_n) begin
                exp_v[l] = 1'b1;
                exp_d[l] = rq[l][0].d;
                void'(rq[l].pop_front());
            end
        end
        edge_n++;
    endtask

    task automatic check_all();
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("rd_valid[lat%0d]", l + 1), {7'b0, rv[l]}, {7'b0, exp_v[l]});
            chk($sformatf("data_bus_out[lat%0d]", l + 1), dout[l], exp_d[l]);
            chk($sformatf("ready[lat%0d]", l + 1), {7'b0, rdy[l]}, {7'b0, (since >= DEPTH) && !rst});
            chk($sformatf("req_dropped[lat%0d]", l + 1), {7'b0, drop[l]}, {7'b0, exp_drop});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic en, input logic rw, input logic [3:0] a, input logic [7:0] d);
        mem_enable  = en;
        read_write  = rw;
        address_bus = a;
        data_bus_in = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic       rw;
        logic [3:0] a;
        logic [7:0] d;
        logic       ev1;
        logic [7:0] ed1;
        logic       ev3;
        logic [7:0] ed3;
    } vec_t;

    vec_t vecs [16];
    int   pulses;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 4'd3, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 4'd5, 8'h40, 1'b0, 8'hA5, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 4'd5, 8'h00, 1'b1, 8'h40, 1'b1, 8'hA5};
        vecs[4]  = '{1'b1, 1'b0, 4'd5, 8'h99, 1'b0, 8'h40, 1'b0, 8'hA5};
        vecs[5]  = '{1'b1, 1'b1, 4'd5, 8'h00, 1'b1, 8'h99, 1'b1, 8'h40};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h99, 1'b0, 8'h40};
        vecs[7]  = '{1'b1, 1'b0, 4'd0, 8'h11, 1'b0, 8'h99, 1'b1, 8'h99};
        vecs[8]  = '{1'b1, 1'b0, 4'd1, 8'h22, 1'b0, 8'h99, 1'b0, 8'h99};
        vecs[9]  = '{1'b1, 1'b0, 4'd2, 8'h33, 1'b0, 8'h99, 1'b0, 8'h99};
        vecs[10] = '{1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'h11, 1'b0, 8'h99};
        vecs[11] = '{1'b1, 1'b1, 4'd1, 8'h00, 1'b1, 8'h22, 1'b0, 8'h99};
        vecs[12] = '{1'b1, 1'b1, 4'd2, 8'h00, 1'b1, 8'h33, 1'b1, 8'h11};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h33, 1'b1, 8'h22};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h33, 1'b1, 8'h33};
        vecs[15] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h33, 1'b0, 8'h33};

        edge_n = 0;
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        apply_reset();

        // Init sweep, then read every word back.
        for (int i = 0; i < DEPTH; i++) tick();
        chk("ready after init", {7'b0, rdy[0]}, 8'h01);
        pulses = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) drive(1'b1, 1'b1, 4'(i), 8'h00);
            else drive(1'b0, 1'b0, 4'd0, 8'h00);
            tick();
            if (rv[0]) pulses++;
            if (rv[0]) chk("init word", dout[0], 8'h00);
        end
        chk("init read pulses", 8'(pulses), 8'd16);

        // Directed vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].rw, vecs[i].a, vecs[i].d);
            tick();
            chk($sformatf("vec%0d v1", i), {7'b0, rv[0]}, {7'b0, vecs[i].ev1});
            chk($sformatf("vec%0d d1", i), dout[0], vecs[i].ed1);
            chk($sformatf("vec%0d v3", i), {7'b0, rv[2]}, {7'b0, vecs[i].ev3});
            chk($sformatf("vec%0d d3", i), dout[2], vecs[i].ed3);
        end

        // Request during init is dropped and leaves word 0 cleared.
        apply_reset();
        drive(1'b1, 1'b0, 4'd0, 8'hFF);
        tick();
        chk("drop pulse", {7'b0, drop[0]}, 8'h01);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        chk("drop one cycle", {7'b0, drop[0]}, 8'h00);
        for (int i = 0; i < DEPTH; i++) tick();
        drive(1'b1, 1'b1, 4'd0, 8'h00);
        tick();
        chk("word0 after dropped write", dout[0], 8'h00);
        chk("word0 valid", {7'b0, rv[0]}, 8'h01);

        // Reset with a read in flight in the latency-2 pipe.
        drive(1'b1, 1'b0, 4'd9, 8'h7E);
        tick();
        drive(1'b1, 1'b1, 4'd9, 8'h00);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        rst = 1'b1;
        model_reset();
        #1;
        chk("lat2 no valid in reset", {7'b0, rv[1]}, 8'h00);
        chk("lat1 data cleared", dout[0], 8'h00);
        tick();
        chk("lat2 still no valid", {7'b0, rv[1]}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick();
        drive(1'b1, 1'b1, 4'd9, 8'h00);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        chk("word9 recleared", dout[1], 8'h00);
        chk("word9 valid lat2", {7'b0, rv[1]}, 8'h01);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
